// File: rtl/vga_sync_decoder_pkg.sv
// ---------------------------------------------------------------------------
// | vga_sync_decoder_pkg                                                    |
// | Shared counter width, saturation value, FSM states and helpers for the  |
// | VGA sync decoder.                                                       |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package vga_sync_decoder_pkg;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_SAT = 10'h3FF;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_VERIFY  = 2'd2,
    ST_LOCKED  = 2'd3
  } dec_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_decoder_edge.sv
// ---------------------------------------------------------------------------
// | vga_sync_edge                                                           |
// | Two-register sync sampler with polarity-aware assertion-edge pulse.     |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module vga_sync_edge #(
  parameter logic ACT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic assert_pulse
);

  logic r_q1;
  logic r_q2;

  // Preset to the inactive level so a sync already active at reset release
  // still produces one assertion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q1 <= ~ACT;
      r_q2 <= ~ACT;
    end else begin
      r_q1 <= sync_in;
      r_q2 <= r_q1;
    end
  end

  assign assert_pulse = (r_q1 == ACT) && (r_q2 != ACT);

endmodule

`default_nettype wire

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// | vga_sync_decoder                                                        |
// | Measures incoming HS/VS timing, regenerates HCOUNT/VCOUNT, LOCKED, DE.  |
// | Optional: define VGA_DEC_ERRCNT_EN to add the ERRCNT lock-loss counter. |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter logic [CNT_W-1:0] H_SYNC_START = 10'd3,
  parameter logic [CNT_W-1:0] V_SYNC_START = 10'd3,
  parameter logic [CNT_W-1:0] H_DISPLAY    = 10'd1,
  parameter logic [CNT_W-1:0] V_DISPLAY    = 10'd1,
  parameter logic             HS_ACT       = 1'b0,
  parameter logic             VS_ACT       = 1'b0,
  parameter logic [3:0]       LOCK_FRAMES  = 4'd2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vga_hs,
  input  logic             vga_vs,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic [CNT_W-1:0] htotal,
  output logic [CNT_W-1:0] vtotal,
  output logic             locked,
  output logic             de
`ifdef VGA_DEC_ERRCNT_EN
  ,
  output logic [7:0]       errcnt
`endif
);

  logic w_hs_edge;
  logic w_vs_edge;

  vga_sync_edge #(.ACT(HS_ACT)) u_hs_edge (
    .clk          (clk),
    .rst          (rst),
    .sync_in      (vga_hs),
    .assert_pulse (w_hs_edge)
  );

  vga_sync_edge #(.ACT(VS_ACT)) u_vs_edge (
    .clk          (clk),
    .rst          (rst),
    .sync_in      (vga_vs),
    .assert_pulse (w_vs_edge)
  );

  dec_state_t       r_state;
  dec_state_t       w_state_nxt;
  logic [3:0]       r_match;
  logic [3:0]       w_match_nxt;
  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic [CNT_W-1:0] r_htotal;
  logic [CNT_W-1:0] r_vtotal;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_line_cnt;
  logic [CNT_W-1:0] r_meas_h;
  logic             r_meas_valid;
  logic             r_de;
  logic [CNT_W-1:0] w_hcount_nxt;
  logic [CNT_W-1:0] w_vcount_nxt;
  logic             w_timeout;
  logic             w_line_bad;
  logic             w_frame_bad;

  always_comb begin
    w_hcount_nxt = w_hs_edge ? H_SYNC_START : sat_inc(r_hcount);
    w_vcount_nxt = r_vcount;
    if (w_vs_edge)
      w_vcount_nxt = V_SYNC_START;
    else if (w_hs_edge)
      w_vcount_nxt = sat_inc(r_vcount);
    // An HS edge on the saturated cycle is a recovery, not a timeout.
    w_timeout   = (r_hcount == CNT_SAT) && !w_hs_edge;
    w_line_bad  = w_hs_edge && (r_len != r_htotal);
    w_frame_bad = w_vs_edge && (r_line_cnt != r_vtotal);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    case (r_state)
      ST_SEARCH: begin
        if (w_vs_edge)
          w_state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (w_vs_edge) begin
          if (r_meas_valid) begin
            w_match_nxt = 4'd1;
            w_state_nxt = (LOCK_FRAMES <= 4'd1) ? ST_LOCKED : ST_VERIFY;
          end else begin
            w_state_nxt = ST_SEARCH;
          end
        end
      end
      ST_VERIFY, ST_LOCKED: begin
        if (w_line_bad || w_frame_bad) begin
          w_state_nxt = ST_SEARCH;
        end else if (w_vs_edge) begin
          w_match_nxt = (r_match == 4'hF) ? r_match : r_match + 4'd1;
          if (w_match_nxt >= LOCK_FRAMES)
            w_state_nxt = ST_LOCKED;
        end
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
    if (w_timeout)
      w_state_nxt = ST_SEARCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_SEARCH;
      r_match      <= 4'd0;
      r_hcount     <= '0;
      r_vcount     <= '0;
      r_htotal     <= '0;
      r_vtotal     <= '0;
      r_len        <= '0;
      r_line_cnt   <= '0;
      r_meas_h     <= '0;
      r_meas_valid <= 1'b0;
      r_de         <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_match  <= w_match_nxt;
      r_hcount <= w_hcount_nxt;
      r_vcount <= w_vcount_nxt;
      r_len    <= w_hs_edge ? {{(CNT_W-1){1'b0}}, 1'b1} : sat_inc(r_len);
      // Lines per frame: an HS edge coinciding with VS belongs to the new frame.
      if (w_vs_edge)
        r_line_cnt <= {{(CNT_W-1){1'b0}}, w_hs_edge};
      else if (w_hs_edge)
        r_line_cnt <= sat_inc(r_line_cnt);
      if (r_state != ST_MEASURE) begin
        r_meas_valid <= 1'b0;
      end else if (w_hs_edge && !r_meas_valid) begin
        r_meas_h     <= r_len;
        r_meas_valid <= 1'b1;
      end
      if ((r_state == ST_MEASURE) &&
          ((w_state_nxt == ST_VERIFY) || (w_state_nxt == ST_LOCKED))) begin
        r_htotal <= r_meas_h;
        r_vtotal <= r_line_cnt;
      end
      r_de <= (w_state_nxt == ST_LOCKED) && (w_hcount_nxt < H_DISPLAY) &&
              (w_vcount_nxt < V_DISPLAY);
    end
  end

`ifdef VGA_DEC_ERRCNT_EN
  logic       w_drop;
  logic [7:0] r_errcnt;

  assign w_drop = (r_state == ST_LOCKED) && (w_state_nxt == ST_SEARCH);

  always_ff @(posedge clk) begin
    if (rst)
      r_errcnt <= 8'd0;
    else if (w_drop && (r_errcnt != 8'hFF))
      r_errcnt <= r_errcnt + 8'd1;
  end

  assign errcnt = r_errcnt;
`endif

  assign hcount = r_hcount;
  assign vcount = r_vcount;
  assign htotal = r_htotal;
  assign vtotal = r_vtotal;
  assign locked = (r_state == ST_LOCKED);
  assign de     = r_de;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// | tb_vga_sync_decoder                                                     |
// | Directed bench: 7-clk lines, 2-clk HS, 4-line frames, both polarities.  |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_sync_decoder;

  logic       clk;
  logic       rst;
  logic       hs;
  logic       vs;
  logic       hs_i;
  logic       vs_i;
  logic [9:0] hcount, vcount, htotal, vtotal;
  logic       locked, de;
  logic [9:0] hcount_i, vcount_i, htotal_i, vtotal_i;
  logic       locked_i, de_i;
`ifdef VGA_DEC_ERRCNT_EN
  logic [7:0] errcnt, errcnt_i;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int src_v, src_h, src_len;

  assign hs_i = ~hs;
  assign vs_i = ~vs;

  vga_sync_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .vga_hs (hs),
    .vga_vs (vs),
    .hcount (hcount),
    .vcount (vcount),
    .htotal (htotal),
    .vtotal (vtotal),
    .locked (locked),
    .de     (de)
`ifdef VGA_DEC_ERRCNT_EN
    ,
    .errcnt (errcnt)
`endif
  );

  vga_sync_decoder #(
    .H_DISPLAY (10'd8),
    .V_DISPLAY (10'd5),
    .HS_ACT    (1'b1),
    .VS_ACT    (1'b1)
  ) dut_inv (
    .clk    (clk),
    .rst    (rst),
    .vga_hs (hs_i),
    .vga_vs (vs_i),
    .hcount (hcount_i),
    .vcount (vcount_i),
    .htotal (htotal_i),
    .vtotal (vtotal_i),
    .locked (locked_i),
    .de     (de_i)
`ifdef VGA_DEC_ERRCNT_EN
    ,
    .errcnt (errcnt_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read 1 ns after the rising edge.
  task automatic step(input logic act_h, input logic act_v);
    @(negedge clk);
    hs = ~act_h;
    vs = ~act_v;
    @(posedge clk);
    #1;
  endtask

  task automatic src_step();
    logic ah, av;
    ah = (src_h == 3) || (src_h == 4);
    av = ((src_v == 3) && (src_h >= 3)) || ((src_v == 0) && (src_h < 3));
    step(ah, av);
    src_h++;
    if (src_h >= src_len) begin
      src_h   = 0;
      src_len = 7;
      src_v   = (src_v + 1) % 4;
    end
  endtask

  task automatic run_until(input int v, input int h);
    int pv, ph;
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      pv = src_v;
      ph = src_h;
      src_step();
      hit = (pv == v) && (ph == h);
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_until: position (%0d,%0d) not reached", v, h);
    end
  endtask

  initial begin
    rst     = 1'b1;
    hs      = 1'b1;
    vs      = 1'b1;
    src_v   = 1;
    src_h   = 0;
    src_len = 7;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_hcount", hcount, 0);
    check_val("rst_vcount", vcount, 0);
    check_val("rst_htotal", htotal, 0);
    check_val("rst_vtotal", vtotal, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_de", de, 0);
`ifdef VGA_DEC_ERRCNT_EN
    check_val("rst_errcnt", errcnt, 0);
`endif
    rst = 1'b0;

    // First HS edge after reset
    run_until(1, 4);
    check_val("hs_load_hcount", hcount, 3);
    check_val("hs_inc_vcount", vcount, 1);

    // VS and HS asserted on the same clock
    run_until(3, 4);
    check_val("vs_hs_hcount", hcount, 3);
    check_val("vs_hs_vcount", vcount, 3);
    check_val("measure_locked", locked, 0);
    run_until(3, 6);
    check_val("hcount_run", hcount, 5);

    run_until(3, 4);
    check_val("htotal_meas", htotal, 7);
    check_val("vtotal_meas", vtotal, 4);
    check_val("verify_locked", locked, 0);
    run_until(2, 4);
    check_val("vcount_line2", vcount, 6);
    run_until(3, 3);
    check_val("pre_lock", locked, 0);
    run_until(3, 4);
    check_val("lock", locked, 1);
    check_val("de_outside", de, 0);
    check_val("inv_htotal", htotal_i, 7);
    check_val("inv_vtotal", vtotal_i, 4);
    check_val("inv_locked", locked_i, 1);
    check_val("inv_de_on", de_i, 1);
    run_until(0, 1);
    check_val("inv_de_h7", de_i, 1);
    run_until(0, 2);
    check_val("inv_de_h8", de_i, 0);

    // Stretch line 1 to 8 clocks
    run_until(0, 6);
    src_len = 8;
    run_until(2, 3);
    check_val("stretch_pre", locked, 1);
    run_until(2, 4);
    check_val("stretch_drop", locked, 0);
    check_val("stretch_inv_drop", locked_i, 0);
    check_val("stretch_htotal", htotal, 7);
    check_val("stretch_vtotal", vtotal, 4);
`ifdef VGA_DEC_ERRCNT_EN
    check_val("stretch_errcnt", errcnt, 1);
`endif
    run_until(3, 4);
    run_until(3, 4);
    check_val("relock_verify", locked, 0);
    run_until(3, 4);
    check_val("relock", locked, 1);

    // HS held inactive while locked
    for (int i = 0; i < 1019; i++) step(1'b0, 1'b0);
    check_val("to_hcount_3fe", hcount, 10'h3FE);
    check_val("to_still_locked", locked, 1);
    for (int i = 0; i < 81; i++) step(1'b0, 1'b0);
    check_val("to_hcount_sat", hcount, 10'h3FF);
    check_val("to_locked", locked, 0);
    check_val("to_vcount", vcount, 3);
`ifdef VGA_DEC_ERRCNT_EN
    check_val("to_errcnt", errcnt, 2);
`endif

    // Recover, then reset mid-frame while locked
    src_v   = 1;
    src_h   = 0;
    src_len = 7;
    run_until(3, 4);
    run_until(3, 4);
    run_until(3, 4);
    check_val("to_relock", locked, 1);
    run_until(0, 6);
    rst = 1'b1;
    src_step();
    check_val("mid_rst_hcount", hcount, 0);
    check_val("mid_rst_vcount", vcount, 0);
    check_val("mid_rst_htotal", htotal, 0);
    check_val("mid_rst_vtotal", vtotal, 0);
    check_val("mid_rst_locked", locked, 0);
    check_val("mid_rst_de", de_i, 0);
`ifdef VGA_DEC_ERRCNT_EN
    check_val("mid_rst_errcnt", errcnt, 0);
`endif
    rst = 1'b0;
    run_until(3, 4);
    check_val("post_rst_measure", locked, 0);
    run_until(3, 4);
    check_val("post_rst_verify", locked, 0);
    check_val("post_rst_htotal", htotal, 7);
    run_until(3, 4);
    check_val("post_rst_lock", locked, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
